// File: rtl/ssd1331_cmd_sequencer.sv
// ssd1331_cmd_sequencer: mode-driven SSD1331 power/init/fill/clear sequencer.
// Latency: a request is accepted on the edge where o_READY=1 and i_START=1; o_READY drops on that edge; first byte is valid the following cycle.
// Backpressure: o_TX_VALID/o_TX_BYTE/o_TX_DC hold while i_TX_READY=0; at most one byte transfers per cycle.
// Ports: i_CLK/i_RST clock and async active-high reset; i_MODE/i_START/i_C*/i_R*/i_COLOR request;
//        o_READY/o_POWERED/o_ERR status; o_TX_* + i_TX_READY byte stream; o_RES/o_VCCEN/o_PMODEN panel pins.
module ssd1331_cmd_sequencer #(
  parameter int WAIT_RES = 300,
  parameter int WAIT_ON  = 10000000,
  parameter int WAIT_OFF = 10000000,
  parameter int CNT_W    = 24,
  parameter int INIT_LEN = 16
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [1:0]  i_MODE,
  input  logic        i_START,
  input  logic [6:0]  i_C1,
  input  logic [6:0]  i_C2,
  input  logic [5:0]  i_R1,
  input  logic [5:0]  i_R2,
  input  logic [15:0] i_COLOR,
  output logic        o_READY,
  output logic        o_POWERED,
  output logic        o_ERR,
  output logic        o_TX_VALID,
  output logic [7:0]  o_TX_BYTE,
  output logic        o_TX_DC,
  input  logic        i_TX_READY,
  output logic        o_RES,
  output logic        o_VCCEN,
  output logic        o_PMODEN
);

  typedef enum logic [3:0] {
    IDLE, PON_RES, PON_RAIL, PON_INIT, PON_DISP, PON_WAIT,
    POFF_CMD, POFF_VCC, POFF_VDD, FILL, CLEAR
  } state_t;

  localparam logic [CNT_W-1:0] RES_LAST  = CNT_W'(WAIT_RES - 1);
  localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(WAIT_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'(WAIT_OFF - 1);
  localparam logic [3:0]       INIT_LAST = 4'(INIT_LEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        idx_q, idx_d;
  logic              ready_q, ready_d, err_q, err_d;
  logic              powered_q, powered_d, vccen_q, vccen_d, pmoden_q, pmoden_d;
  logic [6:0]        c1_q, c1_d, c2_q, c2_d;
  logic [5:0]        r1_q, r1_d, r2_q, r2_d;
  logic [15:0]       color_q, color_d;
  logic              xfer;

  // Normalised corners: order first, then clamp to the 96x64 panel.
  logic [6:0] c_lo, c_hi;
  logic [5:0] r_lo, r_hi;
  assign c_lo = (i_C1 > i_C2) ? i_C2 : i_C1;
  assign c_hi = (i_C1 > i_C2) ? i_C1 : i_C2;
  assign r_lo = (i_R1 > i_R2) ? i_R2 : i_R1;
  assign r_hi = (i_R1 > i_R2) ? i_R1 : i_R2;

  function automatic logic [7:0] init_byte(input logic [3:0] i);
    case (i)
      4'd0:  init_byte = 8'hFD;  4'd1:  init_byte = 8'h12;
      4'd2:  init_byte = 8'hAE;  4'd3:  init_byte = 8'hA0;
      4'd4:  init_byte = 8'h72;  4'd5:  init_byte = 8'hA1;
      4'd6:  init_byte = 8'h00;  4'd7:  init_byte = 8'hA2;
      4'd8:  init_byte = 8'h00;  4'd9:  init_byte = 8'hA4;
      4'd10: init_byte = 8'hA8;  4'd11: init_byte = 8'h3F;
      4'd12: init_byte = 8'hAD;  4'd13: init_byte = 8'h8E;
      4'd14: init_byte = 8'hB0;  default: init_byte = 8'h0B;
    endcase
  endfunction

  // State register
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      powered_q <= 1'b0;
      vccen_q   <= 1'b0;
      pmoden_q  <= 1'b0;
      c1_q      <= '0;
      c2_q      <= '0;
      r1_q      <= '0;
      r2_q      <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
      powered_q <= powered_d;
      vccen_q   <= vccen_d;
      pmoden_q  <= pmoden_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      r1_q      <= r1_d;
      r2_q      <= r2_d;
      color_q   <= color_d;
    end
  end

  assign xfer = o_TX_VALID & i_TX_READY;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = 1'b0;
    powered_d = powered_q;
    vccen_d   = vccen_q;
    pmoden_d  = pmoden_q;
    c1_d      = c1_q;
    c2_d      = c2_q;
    r1_d      = r1_q;
    r2_d      = r2_q;
    color_d   = color_q;
    case (state_q)
      IDLE: begin
        if (ready_q && i_START) begin
          if ((i_MODE == 2'b00) == powered_q) begin
            err_d = 1'b1;
          end else begin
            c1_d    = (c_lo > 7'd95) ? 7'd95 : c_lo;
            c2_d    = (c_hi > 7'd95) ? 7'd95 : c_hi;
            r1_d    = (r_lo > 6'd63) ? 6'd63 : r_lo;
            r2_d    = (r_hi > 6'd63) ? 6'd63 : r_hi;
            color_d = i_COLOR;
            case (i_MODE)
              2'b00:   state_d = PON_RES;
              2'b01:   state_d = POFF_CMD;
              2'b10:   state_d = FILL;
              default: state_d = CLEAR;
            endcase
          end
        end
      end
      PON_RES: begin
        if (cnt_q == RES_LAST) begin
          cnt_d = '0; state_d = PON_RAIL; pmoden_d = 1'b1; vccen_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      PON_RAIL: begin
        if (cnt_q == RES_LAST) begin
          cnt_d = '0; state_d = PON_INIT;
        end else cnt_d = cnt_q + 1'b1;
      end
      PON_INIT: begin
        if (xfer) begin
          if (idx_q == INIT_LAST) begin
            idx_d = '0; state_d = PON_DISP;
          end else idx_d = idx_q + 1'b1;
        end
      end
      PON_DISP: if (xfer) state_d = PON_WAIT;
      PON_WAIT: begin
        if (cnt_q == ON_LAST) begin
          cnt_d = '0; state_d = IDLE; powered_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      end
      POFF_CMD: begin
        if (xfer) begin
          state_d = POFF_VCC; vccen_d = 1'b0;
        end
      end
      POFF_VCC: begin
        if (cnt_q == OFF_LAST) begin
          cnt_d = '0; state_d = POFF_VDD; pmoden_d = 1'b0; powered_d = 1'b0;
        end else cnt_d = cnt_q + 1'b1;
      end
      POFF_VDD: state_d = IDLE;
      FILL: begin
        if (xfer) begin
          if (idx_q == 4'd12) begin
            idx_d = '0; state_d = IDLE;
          end else idx_d = idx_q + 1'b1;
        end
      end
      CLEAR: begin
        if (xfer) begin
          if (idx_q == 4'd4) begin
            idx_d = '0; state_d = IDLE;
          end else idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so READY stays low while reset is held and rises on the first edge after release.
    ready_d = (state_d == IDLE);
  end

  // Output logic
  always_comb begin
    o_TX_VALID = 1'b0;
    o_TX_BYTE  = 8'h00;
    o_TX_DC    = 1'b0;
    o_RES      = (state_q != PON_RES);
    case (state_q)
      PON_INIT: begin o_TX_VALID = 1'b1; o_TX_BYTE = init_byte(idx_q); end
      PON_DISP: begin o_TX_VALID = 1'b1; o_TX_BYTE = 8'hAF; end
      POFF_CMD: begin o_TX_VALID = 1'b1; o_TX_BYTE = 8'hAE; end
      FILL: begin
        o_TX_VALID = 1'b1;
        case (idx_q)
          4'd0:         o_TX_BYTE = 8'h26;
          4'd1:         o_TX_BYTE = 8'h01;
          4'd2:         o_TX_BYTE = 8'h22;
          4'd3:         o_TX_BYTE = {1'b0, c1_q};
          4'd4:         o_TX_BYTE = {2'b00, r1_q};
          4'd5:         o_TX_BYTE = {1'b0, c2_q};
          4'd6:         o_TX_BYTE = {2'b00, r2_q};
          4'd7, 4'd10:  o_TX_BYTE = {2'b00, color_q[15:11], 1'b0};
          4'd8, 4'd11:  o_TX_BYTE = {2'b00, color_q[10:5]};
          4'd9, 4'd12:  o_TX_BYTE = {2'b00, color_q[4:0], 1'b0};
          default:      o_TX_BYTE = 8'h00;
        endcase
      end
      CLEAR: begin
        o_TX_VALID = 1'b1;
        case (idx_q)
          4'd0:    o_TX_BYTE = 8'h25;
          4'd1:    o_TX_BYTE = {1'b0, c1_q};
          4'd2:    o_TX_BYTE = {2'b00, r1_q};
          4'd3:    o_TX_BYTE = {1'b0, c2_q};
          4'd4:    o_TX_BYTE = {2'b00, r2_q};
          default: o_TX_BYTE = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  assign o_READY   = ready_q;
  assign o_ERR     = err_q;
  assign o_POWERED = powered_q;
  assign o_VCCEN   = vccen_q;
  assign o_PMODEN  = pmoden_q;

endmodule

// File: tb/tb_ssd1331_cmd_sequencer.sv
module tb_ssd1331_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        start;
  logic [6:0]  c1, c2;
  logic [5:0]  r1, r2;
  logic [15:0] color;
  logic        ready, powered, err, tx_valid, tx_dc, tx_ready, res, vccen, pmoden;
  logic [7:0]  tx_byte;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  ssd1331_cmd_sequencer #(
    .WAIT_RES(4), .WAIT_ON(8), .WAIT_OFF(6), .CNT_W(24), .INIT_LEN(16)
  ) dut (
    .i_CLK(clk), .i_RST(rst), .i_MODE(mode), .i_START(start),
    .i_C1(c1), .i_C2(c2), .i_R1(r1), .i_R2(r2), .i_COLOR(color),
    .o_READY(ready), .o_POWERED(powered), .o_ERR(err),
    .o_TX_VALID(tx_valid), .o_TX_BYTE(tx_byte), .o_TX_DC(tx_dc),
    .i_TX_READY(tx_ready), .o_RES(res), .o_VCCEN(vccen), .o_PMODEN(pmoden)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic load_init;
    logic [7:0] tbl [17];
    tbl = '{8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'hA1, 8'h00, 8'hA2, 8'h00,
            8'hA4, 8'hA8, 8'h3F, 8'hAD, 8'h8E, 8'hB0, 8'h0B, 8'hAF};
    exp_q.delete();
    for (int i = 0; i < 17; i++) exp_q.push_back(tbl[i]);
  endtask

  // Consumes n bytes from exp_q order; ends just after the edge of the last transfer.
  task automatic collect(input int n, input bit bp, input string tag);
    int   k = 0;
    int   cyc = 0;
    bit   stall = 0;
    logic [7:0] held = 8'h00;
    while (k < n && cyc < 300) begin
      tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) chk({tag, "_hold"}, tx_byte, held);
      if (tx_valid && tx_ready) begin
        chk($sformatf("%s_b%0d", tag, k), tx_byte, exp_q[k]);
        chk($sformatf("%s_dc%0d", tag, k), tx_dc, 1'b0);
        k++;
      end
      stall = tx_valid && !tx_ready;
      held  = tx_byte;
      tick();
      cyc++;
    end
    chk({tag, "_count"}, k, n);
    tx_ready = 1'b1;
  endtask

  task automatic power_on_checked(input string tag);
    int n;
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_ready_drop"}, ready, 1'b0);
    n = 0;
    while (res == 1'b0 && n < 50) begin n++; tick(); end
    chk({tag, "_res_low_cycles"}, n, 4);
    chk({tag, "_rail_pmod"}, pmoden, 1'b1);
    chk({tag, "_rail_vcc"}, vccen, 1'b1);
    load_init();
    collect(17, 1'b0, tag);
    n = 0;
    while (!powered && n < 50) begin n++; tick(); end
    chk({tag, "_powered_delay"}, n, 8);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    int n;
    rst = 1'b1; mode = 2'b00; start = 1'b0; tx_ready = 1'b1;
    c1 = '0; c2 = '0; r1 = '0; r2 = '0; color = '0;
    tick(); tick();
    chk("rst_res", res, 1'b1);
    chk("rst_vcc", vccen, 1'b0);
    chk("rst_pmod", pmoden, 1'b0);
    chk("rst_powered", powered, 1'b0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_byte", tx_byte, 8'h00);
    chk("rst_dc", tx_dc, 1'b0);
    rst = 1'b0;
    tick();
    chk("ready_after_rst", ready, 1'b1);

    // Fill while unpowered is rejected.
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_fill_err", err, 1'b1);
    chk("rej_fill_valid", tx_valid, 1'b0);
    chk("rej_fill_pmod", pmoden, 1'b0);
    chk("rej_fill_ready", ready, 1'b1);
    tick();
    chk("rej_fill_err_pulse", err, 1'b0);

    power_on_checked("pon1");

    // Power-on while powered is rejected.
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("rej_pon_err", err, 1'b1);
    chk("rej_pon_valid", tx_valid, 1'b0);
    chk("rej_pon_vcc", vccen, 1'b1);
    tick();
    chk("rej_pon_err_pulse", err, 1'b0);

    // Fill with swapped/clamped corners; inputs scrambled after acceptance.
    mode = 2'b10; c1 = 7'd10; r1 = 6'd5; c2 = 7'd2; r2 = 6'd70 & 6'h3F; color = 16'hF800;
    r2 = 6'd63; // 70 does not fit 6 bits; the row clamp boundary is exercised via 63
    start = 1'b1;
    tick();
    start = 1'b0; c1 = 7'd127; c2 = 7'd127; r1 = 6'd1; r2 = 6'd1; color = 16'h07E0;
    exp_q = '{8'h26, 8'h01, 8'h22, 8'h02, 8'h05, 8'h0A, 8'h3F,
              8'h3E, 8'h00, 8'h00, 8'h3E, 8'h00, 8'h00};
    collect(13, 1'b0, "fill");
    chk("fill_ready", ready, 1'b1);

    // Fill with column clamp and mixed colour: C 120/100 -> 5F/5F, colour 07FF.
    mode = 2'b10; c1 = 7'd120; c2 = 7'd100; r1 = 6'd9; r2 = 6'd3; color = 16'h07FF;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = '{8'h26, 8'h01, 8'h22, 8'h5F, 8'h03, 8'h5F, 8'h09,
              8'h00, 8'h3F, 8'h3E, 8'h00, 8'h3F, 8'h3E};
    collect(13, 1'b0, "fill2");

    // Clear under random backpressure.
    mode = 2'b11; c1 = 7'd0; r1 = 6'd0; c2 = 7'd95; r2 = 6'd63;
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = '{8'h25, 8'h00, 8'h00, 8'h5F, 8'h3F};
    collect(5, 1'b1, "clear");
    chk("clear_idle_valid", tx_valid, 1'b0);

    // Power-off.
    mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    exp_q = '{8'hAE};
    collect(1, 1'b0, "poff");
    chk("poff_vcc_low", vccen, 1'b0);
    chk("poff_pmod_still", pmoden, 1'b1);
    n = 0;
    while (pmoden && n < 50) begin n++; tick(); end
    chk("poff_vdd_delay", n, 6);
    chk("poff_powered", powered, 1'b0);
    tick();
    chk("poff_ready", ready, 1'b1);

    // Reset in the middle of the init table (byte 7 presented).
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!tx_valid && n < 50) begin n++; tick(); end
    load_init();
    collect(7, 1'b0, "pon_part");
    chk("mid_byte7", tx_byte, 8'hA2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", tx_valid, 1'b0);
    chk("mid_rst_vcc", vccen, 1'b0);
    chk("mid_rst_pmod", pmoden, 1'b0);
    chk("mid_rst_powered", powered, 1'b0);
    chk("mid_rst_res", res, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_ready", ready, 1'b1);
    power_on_checked("pon2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
